bp_update_arbiter: RTL and testbench

// - Merges branch-resolution updates from N_RESOLVE branch FUs into the predictor's single write port.
// - Sits between the branch execute/complete stage and the predictor (wr_en/wr_taken/wr_target/wr_pc/wr_bhr).
// - Buffers bursts in an in-order queue and drains one update per cycle, oldest first.
// - Backpressures FUs via a registered stall so no update is ever lost.

---
 rtl/bp_update_arbiter_pkg.sv | 17 +
 rtl/bp_update_fifo.sv | 46 ++++
 rtl/bp_update_arbiter.sv | 107 ++++++++++
 tb/tb_bp_update_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_arbiter_pkg.sv
// rtl/bp_update_arbiter_pkg.sv - shared types for the branch-predictor update arbiter
package bp_update_arbiter_pkg;

    localparam int ADDR_W                = 32;
    localparam int BRANCH_HISTORY_REG_SZ = 8;

    typedef logic [ADDR_W-1:0] addr_t;

    // One training update for the predictor write port
    typedef struct packed {
        logic                             taken;
        addr_t                            pc;
        addr_t                            target;
        logic [BRANCH_HISTORY_REG_SZ-1:0] bhr;
    } bp_update_packet_t;

endpackage

// File: rtl/bp_update_fifo.sv
// rtl/bp_update_fifo.sv - circular buffer with 0..N_RESOLVE pushes and one pop per cycle
module bp_update_fifo
    import bp_update_arbiter_pkg::*;
#(
    parameter int N_RESOLVE = 2,
    parameter int DEPTH     = 8,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic [CNT_W-1:0]                      i_push_cnt,
    input  bp_update_packet_t [N_RESOLVE-1:0]     i_push_data,
    input  logic                                  i_pop,
    output bp_update_packet_t                     o_head
);

    bp_update_packet_t r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;

    // Payload storage: packed entries land in consecutive slots starting at tail
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < N_RESOLVE; i++) begin
            if (CNT_W'(i) < i_push_cnt) begin
                r_mem[r_tail + PTR_W'(i)] <= i_push_data[i];
            end
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy is tracked by the caller
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_tail <= r_tail + i_push_cnt[PTR_W-1:0];
            if (i_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
        end
    end

    assign o_head = r_mem[r_head];

endmodule

// File: rtl/bp_update_arbiter.sv
// rtl/bp_update_arbiter.sv - merges branch resolutions into the single predictor write port
module bp_update_arbiter
    import bp_update_arbiter_pkg::*;
#(
    parameter int N_RESOLVE  = 2,
    parameter int DEPTH      = 8,
    localparam int BHR_DEPTH = BRANCH_HISTORY_REG_SZ,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic [N_RESOLVE-1:0]                 i_rs_valid,
    input  logic [N_RESOLVE-1:0]                 i_rs_taken,
    input  logic [N_RESOLVE-1:0][ADDR_W-1:0]     i_rs_pc,
    input  logic [N_RESOLVE-1:0][ADDR_W-1:0]     i_rs_target,
    input  logic [N_RESOLVE-1:0][BHR_DEPTH-1:0]  i_rs_bhr,
    output logic                                 o_rs_stall,
    output logic                                 o_wr_en,
    output logic                                 o_wr_taken,
    output logic [ADDR_W-1:0]                    o_wr_pc,
    output logic [ADDR_W-1:0]                    o_wr_target,
    output logic [BHR_DEPTH-1:0]                 o_wr_bhr,
    output logic [CNT_W-1:0]                     o_q_count
);

    localparam int IDX_W = (N_RESOLVE > 1) ? $clog2(N_RESOLVE) : 1;

    logic [CNT_W-1:0]                    r_count;
    logic                                r_rs_stall;
    logic                                r_wr_en;
    bp_update_packet_t                   r_wr_pkt;

    bp_update_packet_t [N_RESOLVE-1:0]   w_push_data;
    logic [CNT_W-1:0]                    w_valid_cnt;
    logic [IDX_W-1:0]                    w_slot;
    logic [CNT_W-1:0]                    w_free;
    logic [CNT_W-1:0]                    w_push_cnt;
    logic [CNT_W-1:0]                    w_count_next;
    logic                                w_pop;
    bp_update_packet_t                   w_head;

    // Pack valid ports densely in port order so port 0 (older) lands first
    always_comb begin
        w_push_data = '0;
        w_valid_cnt = '0;
        w_slot      = '0;
        for (int i = 0; i < N_RESOLVE; i++) begin
            if (i_rs_valid[i]) begin
                w_push_data[w_slot].taken  = i_rs_taken[i];
                w_push_data[w_slot].pc     = i_rs_pc[i];
                w_push_data[w_slot].target = i_rs_target[i];
                w_push_data[w_slot].bhr    = i_rs_bhr[i];
                w_slot      = w_slot + IDX_W'(1);
                w_valid_cnt = w_valid_cnt + CNT_W'(1);
            end
        end
    end

    // Excess updates beyond free space (only possible on a stall violation) are dropped
    assign w_free       = CNT_W'(DEPTH) - r_count;
    assign w_push_cnt   = (w_valid_cnt > w_free) ? w_free : w_valid_cnt;
    assign w_pop        = (r_count != '0);
    assign w_count_next = r_count + w_push_cnt - {{(CNT_W-1){1'b0}}, w_pop};

    bp_update_fifo #(
        .N_RESOLVE (N_RESOLVE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push_cnt  (w_push_cnt),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head)
    );

    // Occupancy, stall and the registered predictor write port
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count    <= '0;
            r_rs_stall <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_pkt   <= '0;
        end else begin
            r_count    <= w_count_next;
            r_rs_stall <= (w_count_next > CNT_W'(DEPTH - N_RESOLVE));
            r_wr_en    <= w_pop;
            if (w_pop) begin
                r_wr_pkt <= w_head;
            end
        end
    end

    assign o_rs_stall  = r_rs_stall;
    assign o_wr_en     = r_wr_en;
    assign o_wr_taken  = r_wr_pkt.taken;
    assign o_wr_pc     = r_wr_pkt.pc;
    assign o_wr_target = r_wr_pkt.target;
    assign o_wr_bhr    = r_wr_pkt.bhr;
    assign o_q_count   = r_count;

    // FUs must hold off while stall is high; anything presented then is a protocol error
    a_no_valid_during_stall: assert property (
        @(posedge i_clock) disable iff (i_reset) !(r_rs_stall && (|i_rs_valid))
    );

endmodule

// File: tb/tb_bp_update_arbiter.sv
// tb/tb_bp_update_arbiter.sv - scoreboard bench for bp_update_arbiter
module tb_bp_update_arbiter;
    import bp_update_arbiter_pkg::*;

    logic              clk;
    logic              rst;
    logic [1:0]        rs_valid;
    logic [1:0]        rs_taken;
    logic [1:0][31:0]  rs_pc;
    logic [1:0][31:0]  rs_target;
    logic [1:0][7:0]   rs_bhr;
    logic              rs_stall;
    logic              wr_en;
    logic              wr_taken;
    logic [31:0]       wr_pc;
    logic [31:0]       wr_target;
    logic [7:0]        wr_bhr;
    logic [3:0]        q_count;

    bp_update_packet_t exp_q [$];
    int                checks = 0;
    int                errors = 0;
    int                n_writes = 0;
    bit                mon_en = 0;

    bp_update_arbiter #(.N_RESOLVE(2), .DEPTH(8)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rs_valid  (rs_valid),
        .i_rs_taken  (rs_taken),
        .i_rs_pc     (rs_pc),
        .i_rs_target (rs_target),
        .i_rs_bhr    (rs_bhr),
        .o_rs_stall  (rs_stall),
        .o_wr_en     (wr_en),
        .o_wr_taken  (wr_taken),
        .o_wr_pc     (wr_pc),
        .o_wr_target (wr_target),
        .o_wr_bhr    (wr_bhr),
        .o_q_count   (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every predictor write must match the oldest outstanding expected update
    always @(negedge clk) begin
        bp_update_packet_t e;
        if (wr_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write pc=%0h", wr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_payload", {23'd0, wr_taken, wr_pc, wr_target, wr_bhr}, {23'd0, e});
            end
        end
        if (mon_en) begin
            chk("stall_vs_count", {95'd0, rs_stall}, {95'd0, (q_count > 4'd6)});
            chk("count_bound", {95'd0, (q_count <= 4'd8)}, 96'd1);
        end
    end

    task automatic set_port(input int p, input logic t, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic [7:0] bhr);
        bp_update_packet_t e;
        rs_valid[p]  = 1'b1;
        rs_taken[p]  = t;
        rs_pc[p]     = pc;
        rs_target[p] = tgt;
        rs_bhr[p]    = bhr;
        e.taken = t; e.pc = pc; e.target = tgt; e.bhr = bhr;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [1:0] v, input logic [31:0] base);
        logic [31:0] b1;
        b1 = base + 32'd2;
        rs_valid = 2'b00;
        if (v[0]) set_port(0, base[1], base, base + 32'h1000, base[7:0] ^ 8'hA5);
        if (v[1]) set_port(1, b1[1], b1, b1 + 32'h1000, b1[7:0] ^ 8'hA5);
    endtask

    task automatic idle();
        rs_valid = 2'b00;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || q_count != 4'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, {64'd0, exp_q.size()}, 96'd0);
        @(negedge clk);
    endtask

    initial begin
        int w0;
        int run;
        bit saw_stall;
        rst = 1'b1;
        rs_valid = '0; rs_taken = '0; rs_pc = '0; rs_target = '0; rs_bhr = '0;
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_wr_en", {95'd0, wr_en}, 96'd0);
        chk("rst_stall", {95'd0, rs_stall}, 96'd0);
        chk("rst_qcount", {92'd0, q_count}, 96'd0);
        chk("rst_payload", {23'd0, wr_taken, wr_pc, wr_target, wr_bhr}, 96'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // single update
        @(negedge clk);
        idle();
        set_port(0, 1'b1, 32'h40, 32'h80, 8'h05);
        @(negedge clk);
        idle();
        chk("single_qcount", {92'd0, q_count}, 96'd1);
        chk("single_no_early_wr", {95'd0, wr_en}, 96'd0);
        @(negedge clk);
        chk("single_wr_en", {95'd0, wr_en}, 96'd1);
        @(negedge clk);
        chk("single_wr_en_drop", {95'd0, wr_en}, 96'd0);
        chk("single_payload_hold", {64'd0, wr_pc}, {64'd0, 32'h40});
        wait_drain("single_drain");

        // dual burst: pcs 0x10..0x1A
        w0 = n_writes;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load(2'b11, 32'h10 + 32'(i * 4));
        end
        @(negedge clk);
        idle();
        wait_drain("dual_drain");
        chk("dual_writes", {64'd0, n_writes - w0}, 96'd6);

        // sparse pack: port 1 then port 0
        @(negedge clk);
        load(2'b10, 32'h1FE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) load(2'b01, 32'h300); else idle();
            chk("sparse_qcount_le1", {95'd0, (q_count <= 4'd1)}, 96'd1);
        end
        wait_drain("sparse_drain");

        // fill until stall
        saw_stall = 0;
        w0 = n_writes;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rs_stall) begin
                idle();
                saw_stall = 1;
                chk("fill_peak_count", {92'd0, q_count}, 96'd7);
                break;
            end
            load(2'b11, 32'h400 + 32'(i * 4));
        end
        chk("fill_saw_stall", {95'd0, saw_stall}, 96'd1);
        wait_drain("fill_drain");
        chk("fill_writes", {64'd0, n_writes - w0}, 96'd12);

        // wrap-around: 20 updates at 1/cycle, wr_en continuous once started
        run = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    load(2'b01, 32'h800 + 32'(i * 4));
                end
                @(negedge clk);
                idle();
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (wr_en) begin
                        run = 1;
                        break;
                    end
                end
                for (int i = 0; i < 19; i++) begin
                    @(negedge clk);
                    if (wr_en) run++;
                end
            end
        join
        chk("wrap_continuous", {64'd0, run}, 96'd20);
        wait_drain("wrap_drain");

        // reset mid-burst
        @(negedge clk);
        load(2'b11, 32'hA00);
        @(negedge clk);
        load(2'b11, 32'hA10);
        @(negedge clk);
        load(2'b01, 32'hA20);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_qcount", {92'd0, q_count}, 96'd0);
        chk("midrst_wr_en", {95'd0, wr_en}, 96'd0);
        chk("midrst_stall", {95'd0, rs_stall}, 96'd0);
        set_port(0, 1'b0, 32'hB00, 32'hC00, 8'h3C);
        @(negedge clk);
        idle();
        chk("postrst_no_early_wr", {95'd0, wr_en}, 96'd0);
        @(negedge clk);
        chk("postrst_wr_en", {95'd0, wr_en}, 96'd1);
        wait_drain("postrst_drain");

        chk("scoreboard_empty", {64'd0, exp_q.size()}, 96'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
